// File: rtl/xpar_resp.sv
// xpar_resp: register-mapped responder on the core's parallel bus, bridging a TX and an RX FIFO to host streams.
// Optional build macro PAR_RESP_IRQ_EN adds the IRQ_MASK register (address 4) and the registered irq output.
module xpar_resp #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 8,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] par_addr,
  input  logic [DATA_W-1:0] par_out,
  input  logic              par_we,
  input  logic              par_re,
  output logic [DATA_W-1:0] par_in,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_valid,
  output logic              rx_ready
`ifdef PAR_RESP_IRQ_EN
  ,
  output logic              irq
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
  localparam logic [2:0] A_TX = 3'd0, A_RX = 3'd1, A_ST = 3'd2, A_CTRL = 3'd3;

  logic [DATA_W-1:0] tx_mem [FIFO_DEPTH];
  logic [DATA_W-1:0] rx_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  tx_wr, tx_rd, rx_wr, rx_rd;
  logic [CNT_W-1:0]  tx_cnt, rx_cnt;
  logic              enable, tx_ovf, rx_unf;

  logic              hit, wr_en, rd_en;
  logic [2:0]        reg_sel;
  logic              tx_full, tx_empty, rx_full, rx_empty;
  logic              tx_pop, tx_push_req, tx_push, rx_push, rx_pop_req, rx_pop;
  logic              flush, sticky_clr;
  logic [DATA_W-1:0] status;

  // A simultaneous read and write is a write only, so reads are qualified by ~par_we
  assign hit      = (par_addr[ADDR_W-1:3] == '0);
  assign reg_sel  = par_addr[2:0];
  assign wr_en    = par_we & hit;
  assign rd_en    = par_re & ~par_we & hit;

  assign tx_full  = (tx_cnt == CNT_FULL);
  assign tx_empty = (tx_cnt == '0);
  assign rx_full  = (rx_cnt == CNT_FULL);
  assign rx_empty = (rx_cnt == '0);

  assign tx_valid = enable & ~tx_empty;
  assign rx_ready = enable & ~rx_full;
  assign tx_data  = tx_mem[tx_rd];

  // A host pop in the same cycle frees the slot, so a push into a full FIFO is still accepted
  assign tx_pop      = tx_valid & tx_ready;
  assign tx_push_req = wr_en & (reg_sel == A_TX);
  assign tx_push     = tx_push_req & (~tx_full | tx_pop);
  assign rx_push     = rx_valid & rx_ready;
  assign rx_pop_req  = rd_en & (reg_sel == A_RX);
  assign rx_pop      = rx_pop_req & ~rx_empty;
  assign flush       = wr_en & (reg_sel == A_CTRL) & par_out[1];
  assign sticky_clr  = wr_en & (reg_sel == A_ST);

  always_comb begin
    status        = '0;
    status[0]     = tx_full;
    status[1]     = tx_empty;
    status[2]     = rx_full;
    status[3]     = rx_empty;
    status[4]     = tx_ovf;
    status[5]     = rx_unf;
    status[15:8]  = 8'(tx_cnt);
    status[23:16] = 8'(rx_cnt);
  end

`ifdef PAR_RESP_IRQ_EN
  localparam logic [2:0] A_MASK = 3'd4;
  logic [2:0] irq_mask;
  logic [2:0] irq_cause;

  assign irq_cause = {tx_ovf | rx_unf, tx_empty, ~rx_empty};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      irq_mask <= '0;
      irq      <= 1'b0;
    end else begin
      if (wr_en && reg_sel == A_MASK) irq_mask <= par_out[2:0];
      irq <= |(irq_mask & irq_cause);
    end
  end
`endif

  always_comb begin
    par_in = '0;
    if (rd_en) begin
      case (reg_sel)
        A_RX:    if (!rx_empty) par_in = rx_mem[rx_rd];
        A_ST:    par_in = status;
        A_CTRL:  par_in[0] = enable;
`ifdef PAR_RESP_IRQ_EN
        A_MASK:  par_in[2:0] = irq_mask;
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_wr  <= '0;
      tx_rd  <= '0;
      rx_wr  <= '0;
      rx_rd  <= '0;
      tx_cnt <= '0;
      rx_cnt <= '0;
      tx_ovf <= 1'b0;
      rx_unf <= 1'b0;
      enable <= 1'b0;
    end else begin
      if (flush) begin
        tx_wr  <= '0;
        tx_rd  <= '0;
        rx_wr  <= '0;
        rx_rd  <= '0;
        tx_cnt <= '0;
        rx_cnt <= '0;
      end else begin
        if (tx_push) tx_wr <= tx_wr + PTR_ONE;
        if (tx_pop)  tx_rd <= tx_rd + PTR_ONE;
        if (rx_push) rx_wr <= rx_wr + PTR_ONE;
        if (rx_pop)  rx_rd <= rx_rd + PTR_ONE;
        case ({tx_push, tx_pop})
          2'b10:   tx_cnt <= tx_cnt + CNT_ONE;
          2'b01:   tx_cnt <= tx_cnt - CNT_ONE;
          default: ;
        endcase
        case ({rx_push, rx_pop})
          2'b10:   rx_cnt <= rx_cnt + CNT_ONE;
          2'b01:   rx_cnt <= rx_cnt - CNT_ONE;
          default: ;
        endcase
      end
      // Set events take priority over write-1-to-clear
      tx_ovf <= (tx_push_req & ~tx_push) | (tx_ovf & ~(sticky_clr & par_out[4]));
      rx_unf <= (rx_pop_req & rx_empty) | (rx_unf & ~(sticky_clr & par_out[5]));
      if (wr_en && reg_sel == A_CTRL) enable <= par_out[0];
    end
  end

  always_ff @(posedge clk) begin
    if (tx_push && !flush) tx_mem[tx_wr] <= par_out;
    if (rx_push && !flush) rx_mem[rx_wr] <= rx_data;
  end

endmodule

// File: tb/tb_xpar_resp.sv
// Self-checking bench for xpar_resp: directed scenarios plus random traffic against a queue-based model.
module tb_xpar_resp;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 8;
  localparam int DEPTH  = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [ADDR_W-1:0] par_addr;
  logic [DATA_W-1:0] par_out;
  logic              par_we, par_re;
  logic [DATA_W-1:0] par_in;
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid, tx_ready;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid, rx_ready;
`ifdef PAR_RESP_IRQ_EN
  logic              irq;
`endif

  xpar_resp #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .par_addr(par_addr), .par_out(par_out), .par_we(par_we), .par_re(par_re), .par_in(par_in),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready)
`ifdef PAR_RESP_IRQ_EN
    , .irq(irq)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference model: FIFOs as queues, registers as plain bits
  logic [31:0] txq[$];
  logic [31:0] rxq[$];
  bit m_en, m_ovf, m_unf;
`ifdef PAR_RESP_IRQ_EN
  bit [2:0] m_mask;
  bit       m_irq;
`endif
  bit host_txr;

  task automatic model_reset();
    txq.delete();
    rxq.delete();
    m_en  = 0;
    m_ovf = 0;
    m_unf = 0;
`ifdef PAR_RESP_IRQ_EN
    m_mask = 0;
    m_irq  = 0;
`endif
  endtask

  function automatic logic [31:0] m_status();
    logic [31:0] s;
    s        = '0;
    s[0]     = (txq.size() == DEPTH);
    s[1]     = (txq.size() == 0);
    s[2]     = (rxq.size() == DEPTH);
    s[3]     = (rxq.size() == 0);
    s[4]     = m_ovf;
    s[5]     = m_unf;
    s[15:8]  = 8'(txq.size());
    s[23:16] = 8'(rxq.size());
    return s;
  endfunction

  task automatic step(input logic [7:0] a, input logic we, input logic re, input logic [31:0] d,
                      input logic txr, input logic rxv, input logic [31:0] rxd,
                      output logic [31:0] pin);
    logic [31:0] e_pin;
    bit e_txv, e_rxr;
`ifdef PAR_RESP_IRQ_EN
    bit next_irq;
`endif
    @(negedge clk);
    par_addr = a; par_we = we; par_re = re; par_out = d;
    tx_ready = txr; rx_valid = rxv; rx_data = rxd;
    #1;
    e_txv = m_en && (txq.size() > 0);
    e_rxr = m_en && (rxq.size() < DEPTH);
    e_pin = '0;
    if (re && !we) begin
      case (a)
        8'd1: if (rxq.size() > 0) e_pin = rxq[0];
        8'd2: e_pin = m_status();
        8'd3: e_pin = {31'b0, m_en};
`ifdef PAR_RESP_IRQ_EN
        8'd4: e_pin = {29'b0, m_mask};
`endif
        default: ;
      endcase
    end
    check("par_in", par_in, e_pin);
    check("tx_valid", {31'b0, tx_valid}, {31'b0, e_txv});
    check("rx_ready", {31'b0, rx_ready}, {31'b0, e_rxr});
    if (e_txv) check("tx_data", tx_data, txq[0]);
`ifdef PAR_RESP_IRQ_EN
    check("irq", {31'b0, irq}, {31'b0, m_irq});
    next_irq = |(m_mask & {m_ovf | m_unf, txq.size() == 0, rxq.size() != 0});
`endif
    pin = par_in;
    @(posedge clk);
    if (we && a == 8'd2 && d[4]) m_ovf = 0;
    if (we && a == 8'd2 && d[5]) m_unf = 0;
    if (we && a == 8'd3 && d[1]) begin
      txq.delete();
      rxq.delete();
    end else begin
      if (e_txv && txr) void'(txq.pop_front());
      if (we && a == 8'd0) begin
        if (txq.size() < DEPTH) txq.push_back(d);
        else m_ovf = 1;
      end
      if (re && !we && a == 8'd1) begin
        if (rxq.size() > 0) void'(rxq.pop_front());
        else m_unf = 1;
      end
      if (e_rxr && rxv) rxq.push_back(rxd);
    end
    if (we && a == 8'd3) m_en = d[0];
`ifdef PAR_RESP_IRQ_EN
    if (we && a == 8'd4) m_mask = d[2:0];
    m_irq = next_irq;
`endif
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    logic [31:0] p;
    step(a, 1'b1, 1'b0, d, host_txr, 1'b0, '0, p);
  endtask

  task automatic rd(input logic [7:0] a, output logic [31:0] p);
    step(a, 1'b0, 1'b1, '0, host_txr, 1'b0, '0, p);
  endtask

  task automatic idle(input int n);
    logic [31:0] p;
    for (int i = 0; i < n; i++) step(8'd0, 1'b0, 1'b0, '0, host_txr, 1'b0, '0, p);
  endtask

  task automatic hsend(input logic [31:0] w);
    logic [31:0] p;
    step(8'd0, 1'b0, 1'b0, '0, host_txr, 1'b1, w, p);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] s, p;
    logic [7:0]  a;
    logic [31:0] d;
    int wrk;
    rst = 1'b0;
    par_addr = '0; par_out = '0; par_we = 0; par_re = 0;
    tx_ready = 0; rx_valid = 0; rx_data = '0;
    host_txr = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_tx_valid", {31'b0, tx_valid}, 32'd0);
    check("rst_rx_ready", {31'b0, rx_ready}, 32'd0);
    check("rst_par_in", par_in, 32'd0);
`ifdef PAR_RESP_IRQ_EN
    check("rst_irq", {31'b0, irq}, 32'd0);
`endif
    rst = 1'b1;

    // Enable, push three words, stream them out
    wr(8'd3, 32'd1);
    wr(8'd0, 32'hA5A5_0001);
    #1 check("tx_valid_latency", {31'b0, tx_valid}, 32'd1);
    wr(8'd0, 32'hA5A5_0002);
    wr(8'd0, 32'hA5A5_0003);
    host_txr = 1;
    idle(3);
    host_txr = 0;
    rd(8'd2, s);
    check("tx_empty_after", {31'b0, s[1]}, 32'd1);

    // Overflow with the host stalled
    for (int i = 0; i < 9; i++) wr(8'd0, 32'hB000_0000 + i);
    rd(8'd2, s);
    check("ovf_count", {24'b0, s[15:8]}, 32'd8);
    check("ovf_bit", {31'b0, s[4]}, 32'd1);
    wr(8'd2, 32'h10);
    rd(8'd2, s);
    check("ovf_clear", {31'b0, s[4]}, 32'd0);
    host_txr = 1;
    idle(9);
    host_txr = 0;

    // RX path and underflow
    hsend(32'h1234);
    hsend(32'h5678);
    rd(8'd2, s);
    check("rx_count2", {24'b0, s[23:16]}, 32'd2);
    rd(8'd1, p);
    check("rx_first", p, 32'h1234);
    rd(8'd1, p);
    check("rx_second", p, 32'h5678);
    rd(8'd1, p);
    check("rx_underflow_data", p, 32'd0);
    rd(8'd2, s);
    check("rx_underflow_bit", {31'b0, s[5]}, 32'd1);
    wr(8'd2, 32'h20);

    // Full TX with push and host pop in the same cycle
    for (int i = 0; i < 8; i++) wr(8'd0, 32'hC000_0000 + i);
    host_txr = 1;
    wr(8'd0, 32'hC000_0008);
    host_txr = 0;
    rd(8'd2, s);
    check("full_swap_count", {24'b0, s[15:8]}, 32'd8);
    check("full_swap_no_ovf", {31'b0, s[4]}, 32'd0);

    // Flush and disable
    hsend(32'hD1);
    hsend(32'hD2);
    hsend(32'hD3);
    wr(8'd3, 32'd3);
    rd(8'd2, s);
    check("flush_rx_count", {24'b0, s[23:16]}, 32'd0);
    check("flush_tx_count", {24'b0, s[15:8]}, 32'd0);
    #1 check("flush_rx_ready", {31'b0, rx_ready}, 32'd1);
    wr(8'd3, 32'd0);
    #1 check("dis_rx_ready", {31'b0, rx_ready}, 32'd0);
    check("dis_tx_valid", {31'b0, tx_valid}, 32'd0);

    // Reset in the middle of streaming
    wr(8'd3, 32'd1);
    for (int i = 0; i < 4; i++) wr(8'd0, 32'hE000_0000 + i);
    host_txr = 1;
    idle(1);
    #2 rst = 1'b0;
    #1 check("mid_rst_tx_valid", {31'b0, tx_valid}, 32'd0);
    check("mid_rst_rx_ready", {31'b0, rx_ready}, 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    host_txr = 0;
    rd(8'd2, s);
    check("mid_rst_status", s, 32'h0000_000A);
    rd(8'd3, p);
    check("mid_rst_ctrl", p, 32'd0);

`ifdef PAR_RESP_IRQ_EN
    wr(8'd3, 32'd1);
    wr(8'd4, 32'd1);
    hsend(32'hF00D);
    #1 check("irq_not_yet", {31'b0, irq}, 32'd0);
    idle(1);
    #1 check("irq_high", {31'b0, irq}, 32'd1);
    rd(8'd1, p);
    #1 check("irq_hold", {31'b0, irq}, 32'd1);
    idle(1);
    #1 check("irq_low", {31'b0, irq}, 32'd0);
    wr(8'd4, 32'd0);
`endif

    // Random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      case ($urandom_range(0, 11))
        0, 1:    a = 8'd0;
        2, 3:    a = 8'd1;
        4, 5:    a = 8'd2;
        6:       a = 8'd3;
        7:       a = 8'd4;
        8:       a = 8'd5;
        9:       a = 8'd7;
        10:      a = 8'h10 | 8'($urandom_range(0, 3));
        default: a = 8'h80;
      endcase
      d = $urandom;
      if (a == 8'd3)
        d = {30'b0, ($urandom_range(0, 15) == 0), ($urandom_range(0, 7) != 0)};
      wrk = $urandom_range(0, 3);
      step(a, wrk[0], wrk[1], d, ($urandom_range(0, 2) != 0), ($urandom_range(0, 1) == 1),
           $urandom, p);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
